// File: rtl/m_tlb_assoc.sv
// rtl/m_tlb_assoc.sv - N-way set-associative Sv32 TLB with ASID/G tagging and sfence.vma set sweep
module m_tlb_assoc #(
  parameter int SETS       = 8,
  parameter int WAYS       = 2,
  parameter int ASID_WIDTH = 9
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic [19:0]           i_lk_vpn,
  input  logic [ASID_WIDTH-1:0] i_lk_asid,
  output logic                  o_hit,
  output logic [21:0]           o_ppn,
  output logic [7:0]            o_perm,
  input  logic                  i_fill_we,
  input  logic [19:0]           i_fill_vpn,
  input  logic [ASID_WIDTH-1:0] i_fill_asid,
  input  logic [21:0]           i_fill_ppn,
  input  logic [7:0]            i_fill_perm,
  input  logic                  i_fill_super,
  input  logic                  i_fl_req,
  input  logic                  i_fl_any_vpn,
  input  logic                  i_fl_any_asid,
  input  logic [19:0]           i_fl_vpn,
  input  logic [ASID_WIDTH-1:0] i_fl_asid,
  output logic                  o_fl_busy,
  output logic                  o_fl_done
);

  localparam int IB = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;
  // perm bit order is D,A,G,U,X,W,R,V from bit 7 down to bit 0
  localparam int G_BIT = 5;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  // entry storage; ent_vpn keeps the full VPN, superpages only compare [19:10]
  logic                  ent_v     [SETS][WAYS];
  logic                  ent_super [SETS][WAYS];
  logic [19:0]           ent_vpn   [SETS][WAYS];
  logic [ASID_WIDTH-1:0] ent_asid  [SETS][WAYS];
  logic [21:0]           ent_ppn   [SETS][WAYS];
  logic [7:0]            ent_perm  [SETS][WAYS];
  logic [PW-1:0]         rr_ptr    [SETS];

  state_t                state;
  logic [IB-1:0]         sweep_cnt;
  logic                  busy_q;
  logic                  done_q;
  logic                  fl_any_vpn_q;
  logic                  fl_any_asid_q;
  logic [19:0]           fl_vpn_q;
  logic [ASID_WIDTH-1:0] fl_asid_q;

  logic [IB-1:0]         lk_set4, lk_set_sp;
  logic                  hit4, hit_sp;
  logic [PW-1:0]         way4, way_sp;

  logic [IB-1:0]         fill_set;
  logic                  same_hit, inv_hit;
  logic [PW-1:0]         same_way, inv_way, fill_way;

  assign lk_set4   = i_lk_vpn[IB-1:0];
  assign lk_set_sp = i_lk_vpn[10+IB-1:10];
  assign fill_set  = i_fill_super ? i_fill_vpn[10+IB-1:10] : i_fill_vpn[IB-1:0];

  assign o_fl_busy = busy_q;
  assign o_fl_done = done_q;

  // flush match for one entry against the captured sfence operands
  function automatic logic sweep_hit(input logic sup, input logic [19:0] vpn,
                                     input logic [ASID_WIDTH-1:0] asid, input logic glb);
    logic vm, am;
    vm = fl_any_vpn_q || (sup ? (vpn[19:10] == fl_vpn_q[19:10]) : (vpn == fl_vpn_q));
    am = fl_any_asid_q || ((asid == fl_asid_q) && !glb);
    return vm && am;
  endfunction

  // probe the 4 KiB set and the superpage set; descending scan leaves the lowest matching way
  always_comb begin
    hit4   = 1'b0;
    hit_sp = 1'b0;
    way4   = '0;
    way_sp = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (ent_v[lk_set4][w] && !ent_super[lk_set4][w] &&
          (ent_vpn[lk_set4][w] == i_lk_vpn) &&
          ((ent_asid[lk_set4][w] == i_lk_asid) || ent_perm[lk_set4][w][G_BIT])) begin
        hit4 = 1'b1;
        way4 = PW'(w);
      end
      if (ent_v[lk_set_sp][w] && ent_super[lk_set_sp][w] &&
          (ent_vpn[lk_set_sp][w][19:10] == i_lk_vpn[19:10]) &&
          ((ent_asid[lk_set_sp][w] == i_lk_asid) || ent_perm[lk_set_sp][w][G_BIT])) begin
        hit_sp = 1'b1;
        way_sp = PW'(w);
      end
    end
  end

  // lookup result: 4 KiB hit wins, superpage splices the low VPN bits into the PPN
  always_comb begin
    o_hit  = 1'b0;
    o_ppn  = '0;
    o_perm = '0;
    if (!busy_q) begin
      if (hit4) begin
        o_hit  = 1'b1;
        o_ppn  = ent_ppn[lk_set4][way4];
        o_perm = ent_perm[lk_set4][way4];
      end else if (hit_sp) begin
        o_hit  = 1'b1;
        o_ppn  = {ent_ppn[lk_set_sp][way_sp][21:10], i_lk_vpn[9:0]};
        o_perm = ent_perm[lk_set_sp][way_sp];
      end
    end
  end

  // victim choice: same-translation way, else lowest invalid way, else round-robin pointer
  always_comb begin
    same_hit = 1'b0;
    inv_hit  = 1'b0;
    same_way = '0;
    inv_way  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (ent_v[fill_set][w] && (ent_super[fill_set][w] == i_fill_super) &&
          (ent_asid[fill_set][w] == i_fill_asid) &&
          (i_fill_super ? (ent_vpn[fill_set][w][19:10] == i_fill_vpn[19:10])
                        : (ent_vpn[fill_set][w] == i_fill_vpn))) begin
        same_hit = 1'b1;
        same_way = PW'(w);
      end
      if (!ent_v[fill_set][w]) begin
        inv_hit = 1'b1;
        inv_way = PW'(w);
      end
    end
    if (same_hit)     fill_way = same_way;
    else if (inv_hit) fill_way = inv_way;
    else              fill_way = rr_ptr[fill_set];
  end

  // refill, full flush and the set-sweep state machine
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state         <= S_IDLE;
      sweep_cnt     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fl_any_vpn_q  <= 1'b0;
      fl_any_asid_q <= 1'b0;
      fl_vpn_q      <= '0;
      fl_asid_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) ent_v[s][w] <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_fl_req) begin
            if (i_fl_any_vpn && i_fl_any_asid) begin
              for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) ent_v[s][w] <= 1'b0;
              done_q <= 1'b1;
            end else begin
              fl_any_vpn_q  <= i_fl_any_vpn;
              fl_any_asid_q <= i_fl_any_asid;
              fl_vpn_q      <= i_fl_vpn;
              fl_asid_q     <= i_fl_asid;
              sweep_cnt     <= '0;
              busy_q        <= 1'b1;
              state         <= S_SWEEP;
            end
          end else if (i_fill_we) begin
            ent_v[fill_set][fill_way]     <= 1'b1;
            ent_super[fill_set][fill_way] <= i_fill_super;
            ent_vpn[fill_set][fill_way]   <= i_fill_vpn;
            ent_asid[fill_set][fill_way]  <= i_fill_asid;
            ent_ppn[fill_set][fill_way]   <= i_fill_ppn;
            ent_perm[fill_set][fill_way]  <= i_fill_perm;
            if (!same_hit && !inv_hit)
              rr_ptr[fill_set] <= (rr_ptr[fill_set] == PW'(WAYS-1)) ? '0 : rr_ptr[fill_set] + 1'b1;
          end
        end
        S_SWEEP: begin
          for (int w = 0; w < WAYS; w++) begin
            if (ent_v[sweep_cnt][w] &&
                sweep_hit(ent_super[sweep_cnt][w], ent_vpn[sweep_cnt][w],
                          ent_asid[sweep_cnt][w], ent_perm[sweep_cnt][w][G_BIT]))
              ent_v[sweep_cnt][w] <= 1'b0;
          end
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == IB'(SETS-1)) begin
            sweep_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/m_tlb_assoc.md
# m_tlb_assoc

Parametrised N-way set-associative translation lookaside buffer for the Sv32 MMU, replacing the direct-mapped per-port TLB caches. It holds both 4 KiB pages and 4 MiB superpages, tags entries with an ASID, and honours the global (G) bit. It implements `sfence.vma` semantics as a selective flush by VPN and/or ASID through a set-sweep state machine. One instance serves the instruction side and one the data side; the page walker fills it, and the MMU front end looks it up combinationally.

## Interface
Parameters:
- SETS, 8, number of sets; power of two, 2..64
- WAYS, 2, associativity; 1..8
- ASID_WIDTH, 9, ASID tag width (satp[30:22])

Ports:
- CLK  in  1  clock
- RST_X  in  1  synchronous reset, active-low
- i_lk_vpn  in  20  lookup VPN (vaddr[31:12])
- i_lk_asid  in  ASID_WIDTH  current ASID
- o_hit  out  1  lookup hit
- o_ppn  out  22  translated PPN (superpage: PPN[21:10] concatenated with i_lk_vpn[9:0])
- o_perm  out  8  D,A,G,U,X,W,R,V of the hitting entry
- i_fill_we  in  1  refill strobe from the page walker
- i_fill_vpn  in  20  refill VPN
- i_fill_asid  in  ASID_WIDTH  refill ASID
- i_fill_ppn  in  22  refill PPN
- i_fill_perm  in  8  refill permission bits
- i_fill_super  in  1  entry is a 4 MiB superpage (leaf found at L1)
- i_fl_req  in  1  flush request (sfence.vma)
- i_fl_any_vpn  in  1  rs1==x0: match every VPN
- i_fl_any_asid  in  1  rs2==x0: match every ASID
- i_fl_vpn  in  20  flush VPN
- i_fl_asid  in  ASID_WIDTH  flush ASID
- o_fl_busy  out  1  selective sweep in progress
- o_fl_done  out  1  one-cycle flush-complete pulse

## Operation
- Storage per entry: V, super, VPN tag, ASID, PPN, perm[7:0]. Register array; the lookup read path is combinational.
- Indexing: a 4 KiB entry uses set vpn[IB-1:0]. A superpage entry uses set vpn[10+IB-1:10]. IB = log2(SETS).
- Lookup probes both candidate sets in parallel.
  - Match condition: V && super flag agrees with the probe type && tag equal (superpage compares vpn[19:10] only) && (asid equal || perm.G).
  - A 4 KiB hit takes priority over a superpage hit. Within a set, the lowest-index matching way wins.
- Replacement: each set has a round-robin pointer (width log2(WAYS), min 1).
  - A fill into a set first overwrites a way already matching the same vpn/asid/super, if one exists.
  - Otherwise it uses the lowest-index invalid way.
  - Otherwise it uses the pointer way, and the pointer then advances modulo WAYS. The pointer changes only on this path.
- States: IDLE, SWEEP.
  - IDLE, i_fl_req with any_vpn && any_asid: every V clears at the next edge and o_fl_done pulses the following cycle. State stays IDLE.
  - IDLE, any other i_fl_req: capture the flush operands, set the counter to 0, go to SWEEP.
  - SWEEP: each cycle, examine set[counter] in all ways and clear V where the flush matches.
    - VPN match: any_vpn, or the tag matches i_fl_vpn (superpage tag against i_fl_vpn[19:10]).
    - ASID match: any_asid, or (asid == i_fl_asid && !G). Global entries survive ASID-specific flushes.
    - Counter increments each cycle. When counter == SETS-1, go to IDLE and assert o_fl_done.
- While o_fl_busy=1: o_hit is forced to 0, i_fill_we is ignored, and i_fl_req is ignored.
- i_fill_we and i_fl_req in the same IDLE cycle: the flush is taken and the fill is dropped.
- Reset: all V=0, all pointers=0, state IDLE, counter 0, o_fl_busy=0, o_fl_done=0. With V=0, o_hit=0 and o_ppn/o_perm=0.

## Timing
- Lookup: zero latency; o_hit/o_ppn/o_perm are valid in the same cycle as i_lk_*.
- Fill: written at the edge where i_fill_we=1 is sampled; a lookup hits from the next cycle.
- Full flush:
  - Request sampled at edge t.
  - Entries are invalid from cycle t+1, when o_fl_done=1.
  - o_fl_busy stays 0 throughout.
- Selective flush:
  - Request sampled at edge t.
  - o_fl_busy=1 for cycles t+1 .. t+SETS.
  - o_fl_done=1 at cycle t+SETS+1 with o_fl_busy=0.
  - A new request is accepted from t+SETS+1.
- Reset asserted mid-sweep returns to IDLE at the next edge. No done pulse is generated, and every entry is invalidated.

## Test plan
- Reset, then lookup vpn 0x12345 asid 1 -> o_hit=0. Fill vpn 0x12345 ppn 0x00ABC perm 0xCF asid 1 -> next-cycle lookup gives o_hit=1, o_ppn=0x00ABC, o_perm=0xCF. Same vpn with asid 2 -> o_hit=0.
- Superpage: fill vpn 0x40000 super=1 ppn 0x12C00. Lookup vpn 0x40155 -> o_hit=1, o_ppn=0x12D55. Lookup vpn 0x80155 -> o_hit=0.
- SETS=8, WAYS=2: fill vpns 0x00008, 0x00010, 0x00018 (all set 0) -> 0x00008 is evicted (pointer way 0) and the other two still hit. A further fill of 0x00020 evicts 0x00010.
- Selective flush asid 1 (any_vpn=1) with a G entry (asid 1) and a non-G entry (asid 1) present -> o_fl_busy high for exactly 8 cycles, o_fl_done on the 9th. The G entry still hits; the non-G entry misses.
- Full flush with 16 valid entries -> o_fl_busy never rises, o_fl_done in the next cycle, all lookups miss. Fill plus flush request in the same cycle -> the filled VPN misses afterwards.
- Reset asserted at sweep cycle 3 -> o_fl_busy=0 and o_fl_done=0 after the edge, all lookups miss, and a new flush request is accepted in the next cycle.
